// File: rtl/ahb_mem_responder_pkg.sv
// ahb_mem_responder_pkg - shared AHB-Lite encodings, responder state type and wrap helper.
// Rev 1.0
`default_nettype none

package ahb_mem_responder_pkg;

  typedef enum logic [3:0] {
    BURST_SINGLE = 4'd0,
    BURST_INCR   = 4'd1,
    BURST_WRAP4  = 4'd2,
    BURST_INCR4  = 4'd3,
    BURST_WRAP8  = 4'd4,
    BURST_INCR8  = 4'd5,
    BURST_WRAP16 = 4'd6,
    BURST_INCR16 = 4'd7
  } burst_t;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic        HRESP_OKAY          = 1'b0;
  localparam logic        HRESP_ERROR         = 1'b1;
  localparam logic [2:0]  HSIZE_WORD          = 3'b010;
  localparam logic [31:0] WRAP4_BOUNDARY_MASK = 32'hFFFF_FFF0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } resp_state_t;

  // Next beat of a 16-byte wrapping burst: low nibble advances modulo 16.
  function automatic logic [31:0] wrap4_next(input logic [31:0] base, input logic [31:0] prev);
    return base | ((prev + 32'd4) & ~WRAP4_BOUNDARY_MASK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_mem_responder_if.sv
// ahb_mem_responder_if - AHB-Lite bus bundle between the transfer initiator and the responder.
// Rev 1.0
`default_nettype none

interface ahb_mem_responder_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hrdata, hready, hresp
  );
endinterface

`default_nettype wire

// File: rtl/ahb_mem_responder_wrap4_tracker.sv
// ahb_mem_responder_wrap4_tracker - follows an open WRAP4 burst and predicts the next SEQ address.
// Rev 1.0
`default_nettype none

module ahb_mem_responder_wrap4_tracker
  import ahb_mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        accept,
  input  logic        xfer_err,
  input  logic [1:0]  htrans,
  input  logic [3:0]  hburst,
  input  logic [31:0] haddr,
  output logic        seq_ok,
  output logic        burst_open
);

  logic [31:0] base;
  logic [31:0] prev;
  logic [1:0]  beat;
  logic        open_q;

  assign burst_open = open_q;
  assign seq_ok     = (haddr == wrap4_next(base, prev));

  // Any rejected transfer closes the burst; BUSY/IDLE never reach here, so the count holds.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      open_q <= 1'b0;
      base   <= '0;
      prev   <= '0;
      beat   <= '0;
    end else if (accept) begin
      if (xfer_err) begin
        open_q <= 1'b0;
      end else if (htrans == HTRANS_NONSEQ) begin
        open_q <= (hburst == BURST_WRAP4);
        base   <= haddr & WRAP4_BOUNDARY_MASK;
        prev   <= haddr;
        beat   <= '0;
      end else if (htrans == HTRANS_SEQ) begin
        prev <= haddr;
        beat <= beat + 2'd1;
        if (beat == 2'd2) begin
          open_q <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ahb_mem_responder.sv
// ahb_mem_responder - AHB-Lite word-memory responder with programmable wait states and WRAP4 checking.
// Rev 1.0
`default_nettype none

module ahb_mem_responder
  import ahb_mem_responder_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               rstn,
  ahb_mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  resp_state_t      state;
  resp_state_t      state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic [IDX_W-1:0] idx_q;
  logic             wr_q;
  logic [31:0]      rdata_q;
  logic [31:0]      mem [MEM_DEPTH];

  logic             ready_c;
  logic             resp_c;
  logic             addr_valid;
  logic             accept;
  logic             take;
  logic             xfer_err;
  logic             seq_ok;
  logic             burst_open;
  logic [IDX_W-1:0] idx_a;
  logic             load_rd;
  logic [31:0]      rd_val;

  assign idx_a      = bus.haddr[IDX_W+1:2];
  assign addr_valid = bus.hsel && ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));
  // The address phase offered while ERR2 is on the bus is dropped on purpose.
  assign accept     = addr_valid && ready_c && (state != ST_ERR2);
  assign take       = accept && !xfer_err;

  assign xfer_err = (bus.haddr[1:0] != 2'b00)
                 || (bus.hsize != HSIZE_WORD)
                 || (bus.haddr >= 32'(4 * MEM_DEPTH))
                 || !((bus.hburst == BURST_SINGLE) || (bus.hburst == BURST_WRAP4))
                 || ((bus.htrans == HTRANS_SEQ) && !(burst_open && seq_ok));

  ahb_mem_responder_wrap4_tracker u_wrap4_tracker (
    .clk        (clk),
    .rstn       (rstn),
    .accept     (accept),
    .xfer_err   (xfer_err),
    .htrans     (bus.htrans),
    .hburst     (bus.hburst),
    .haddr      (bus.haddr),
    .seq_ok     (seq_ok),
    .burst_open (burst_open)
  );

  always_comb begin
    ready_c = 1'b1;
    resp_c  = HRESP_OKAY;
    case (state)
      ST_WAIT: ready_c = 1'b0;
      ST_ERR1: begin
        ready_c = 1'b0;
        resp_c  = HRESP_ERROR;
      end
      ST_ERR2: resp_c = HRESP_ERROR;
      default: ;
    endcase
  end

  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (xfer_err) begin
            state_nx = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nx = ST_WAIT;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_WAIT: state_nx = (32'(wait_cnt) == 32'(WAIT_STATES - 1)) ? ST_DONE : ST_WAIT;
      ST_ERR1: state_nx = ST_ERR2;
      ST_ERR2: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Read data is captured on the edge entering DONE. On a zero-wait back-to-back read the
  // preceding write lands in memory on that same edge, so its data is forwarded instead.
  always_comb begin
    load_rd = 1'b0;
    rd_val  = mem[idx_q];
    if (state == ST_WAIT) begin
      load_rd = (state_nx == ST_DONE) && !wr_q;
    end else if (take && (WAIT_STATES == 0) && !bus.hwrite) begin
      load_rd = 1'b1;
      rd_val  = (state == ST_DONE && wr_q && idx_q == idx_a) ? bus.hwdata : mem[idx_a];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= (state == ST_WAIT && state_nx == ST_WAIT) ? wait_cnt + CNT_W'(1) : '0;
      if (take) begin
        idx_q <= idx_a;
        wr_q  <= bus.hwrite;
      end
      if (load_rd) begin
        rdata_q <= rd_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && state == ST_DONE && wr_q) begin
      mem[idx_q] <= bus.hwdata;
    end
  end

  assign bus.hready = ready_c;
  assign bus.hresp  = resp_c;
  assign bus.hrdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_mem_responder.sv
// tb_ahb_mem_responder - directed and randomized checks of two responders (WAIT_STATES 0 and 1).
// Rev 1.0
`default_nettype none

module tb_ahb_mem_responder;
  import ahb_mem_responder_pkg::*;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  bit          sel;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hburst;
  logic [31:0] hwdata;

  ahb_mem_responder_if bus0 ();
  ahb_mem_responder_if bus1 ();

  assign bus0.hsel   = hsel && !sel;
  assign bus1.hsel   = hsel && sel;
  assign bus0.haddr  = haddr;   assign bus1.haddr  = haddr;
  assign bus0.htrans = htrans;  assign bus1.htrans = htrans;
  assign bus0.hwrite = hwrite;  assign bus1.hwrite = hwrite;
  assign bus0.hsize  = hsize;   assign bus1.hsize  = hsize;
  assign bus0.hburst = hburst;  assign bus1.hburst = hburst;
  assign bus0.hwdata = hwdata;  assign bus1.hwdata = hwdata;

  ahb_mem_responder #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (.clk(clk), .rstn(rstn), .bus(bus0));
  ahb_mem_responder #(.MEM_DEPTH(DEPTH), .WAIT_STATES(1)) dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

  logic        rdy;
  logic        resp;
  logic [31:0] rd;
  assign rdy  = sel ? bus1.hready : bus0.hready;
  assign resp = sel ? bus1.hresp  : bus0.hresp;
  assign rd   = sel ? bus1.hrdata : bus0.hrdata;

  int errors = 0;
  int checks = 0;

  // Reference model: memory image, last returned read data and open-burst bookkeeping per DUT.
  logic [31:0] mdl_mem [2][DEPTH];
  logic [31:0] mdl_rd  [2];
  bit          m_open  [2];
  logic [31:0] m_base  [2];
  logic [31:0] m_last  [2];
  int          m_beats [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wrap_next(input bit s);
    return m_base[s] + ((m_last[s] - m_base[s] + 32'd4) % 32'd16);
  endfunction

  function automatic bit expect_err(input bit s, input logic [31:0] a, input logic [2:0] sz,
                                    input logic [3:0] bu, input logic [1:0] tr);
    bit bad;
    bad = (a % 4 != 0) || (sz != 3'b010) || (a >= 4 * DEPTH) || !(bu == 4'd0 || bu == 4'd2);
    if (tr == HTRANS_SEQ) bad = bad || !(m_open[s] && a == wrap_next(s));
    return bad;
  endfunction

  // One complete transfer: address phase, data phase (waits / error pair), model update.
  task automatic xfer(input logic [31:0] a, input bit wr, input logic [31:0] d, input logic [3:0] bu,
                      input logic [1:0] tr, input logic [2:0] sz, input bit busy_after, input string tag);
    bit s;
    bit e;
    int waits;
    s = sel;
    e = expect_err(s, a, sz, bu, tr);
    hsel = 1'b1; haddr = a; htrans = tr; hwrite = wr; hsize = sz; hburst = bu;
    tick();
    if (busy_after) htrans = HTRANS_BUSY;
    else begin hsel = 1'b0; htrans = HTRANS_IDLE; end
    hwdata = d;
    if (e) begin
      chk({tag, "_err1_hready"}, 32'(rdy), 32'd0);
      chk({tag, "_err1_hresp"}, 32'(resp), 32'd1);
      tick();
      chk({tag, "_err2_hready"}, 32'(rdy), 32'd1);
      chk({tag, "_err2_hresp"}, 32'(resp), 32'd1);
      chk({tag, "_err2_hrdata"}, rd, mdl_rd[s]);
      tick();
      m_open[s] = 1'b0;
    end else begin
      waits = 0;
      while (rdy !== 1'b1 && waits < 16) begin
        waits++;
        tick();
      end
      chk({tag, "_waits"}, 32'(waits), s ? 32'd1 : 32'd0);
      chk({tag, "_hresp"}, 32'(resp), 32'd0);
      if (!wr) begin
        chk({tag, "_hrdata"}, rd, mdl_mem[s][a[9:2]]);
        mdl_rd[s] = mdl_mem[s][a[9:2]];
      end else begin
        mdl_mem[s][a[9:2]] = d;
      end
      tick();
      if (tr == HTRANS_NONSEQ) begin
        m_open[s]  = (bu == BURST_WRAP4);
        m_base[s]  = a & ~32'hF;
        m_last[s]  = a;
        m_beats[s] = 1;
      end else begin
        m_last[s] = a;
        m_beats[s]++;
        if (m_beats[s] == 4) m_open[s] = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          kind;
  int          sub;
  logic [31:0] a;
  logic [31:0] d;
  logic [3:0]  bu;
  logic [2:0]  sz;
  logic [1:0]  tr;
  bit          wr;
  bit          corrupt;

  initial begin
    rstn = 1'b0; sel = 1'b0; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE;
    hwrite = 1'b0; hsize = HSIZE_WORD; hburst = BURST_SINGLE; hwdata = '0;
    for (int s = 0; s < 2; s++) begin
      mdl_rd[s] = '0; m_open[s] = 1'b0; m_base[s] = '0; m_last[s] = '0; m_beats[s] = 0;
    end
    tick(); tick();
    chk("rst_hready0", 32'(bus0.hready), 32'd1);
    chk("rst_hresp0", 32'(bus0.hresp), 32'd0);
    chk("rst_hrdata0", bus0.hrdata, 32'd0);
    chk("rst_hready1", 32'(bus1.hready), 32'd1);
    chk("rst_hresp1", 32'(bus1.hresp), 32'd0);
    chk("rst_hrdata1", bus1.hrdata, 32'd0);
    rstn = 1'b1;
    tick();

    // Preload words 0..63 of both memories with random data.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int w = 0; w < 64; w++)
        xfer(32'(w * 4), 1'b1, $urandom, BURST_SINGLE, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, "preload");
    end

    sel = 1'b1;
    xfer(32'h40, 1'b1, 32'hDEAD_BEEF, BURST_SINGLE, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, "ws1_wr40");
    xfer(32'h40, 1'b0, 32'h0, BURST_SINGLE, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, "ws1_rd40");
    chk("ws1_rd40_value", mdl_rd[1], 32'hDEAD_BEEF);

    for (int w = 0; w < 4; w++)
      xfer(32'h20 + 32'(w * 4), 1'b1, 32'hA000_0000 + 32'(w), BURST_SINGLE, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, "wrap_pre");
    xfer(32'h28, 1'b0, 32'h0, BURST_WRAP4, HTRANS_NONSEQ, HSIZE_WORD, 1'b1, "wrap_b0");
    xfer(32'h2C, 1'b0, 32'h0, BURST_WRAP4, HTRANS_SEQ, HSIZE_WORD, 1'b1, "wrap_b1");
    xfer(32'h20, 1'b0, 32'h0, BURST_WRAP4, HTRANS_SEQ, HSIZE_WORD, 1'b1, "wrap_b2");
    xfer(32'h24, 1'b0, 32'h0, BURST_WRAP4, HTRANS_SEQ, HSIZE_WORD, 1'b0, "wrap_b3");
    chk("wrap_last_data", mdl_rd[1], 32'hA000_0001);
    xfer(32'h28, 1'b0, 32'h0, BURST_WRAP4, HTRANS_SEQ, HSIZE_WORD, 1'b0, "seq_after_close");

    xfer(32'h28, 1'b0, 32'h0, BURST_WRAP4, HTRANS_NONSEQ, HSIZE_WORD, 1'b1, "werr_b0");
    xfer(32'h2C, 1'b0, 32'h0, BURST_WRAP4, HTRANS_SEQ, HSIZE_WORD, 1'b1, "werr_b1");
    xfer(32'h30, 1'b1, 32'hBAD0_BAD0, BURST_WRAP4, HTRANS_SEQ, HSIZE_WORD, 1'b0, "werr_b2");
    xfer(32'h30, 1'b0, 32'h0, BURST_SINGLE, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, "werr_mem");

    xfer(32'h28, 1'b0, 32'h0, BURST_WRAP4, HTRANS_NONSEQ, HSIZE_WORD, 1'b1, "abort_b0");
    xfer(32'h14, 1'b0, 32'h0, BURST_WRAP4, HTRANS_NONSEQ, HSIZE_WORD, 1'b1, "abort_new");
    xfer(32'h18, 1'b0, 32'h0, BURST_WRAP4, HTRANS_SEQ, HSIZE_WORD, 1'b0, "abort_seq");

    xfer(32'h41, 1'b0, 32'h0, BURST_SINGLE, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, "err_misalign");
    xfer(32'(4 * DEPTH), 1'b1, 32'h5, BURST_SINGLE, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, "err_range");
    xfer(32'h40, 1'b1, 32'h6, BURST_INCR, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, "err_incr");
    xfer(32'h40, 1'b0, 32'h0, BURST_SINGLE, HTRANS_NONSEQ, 3'b000, 1'b0, "err_size");

    // Address phase offered during ERR2 must be ignored.
    hsel = 1'b1; haddr = 32'h41; htrans = HTRANS_NONSEQ; hwrite = 1'b0; hburst = BURST_SINGLE; hsize = HSIZE_WORD;
    tick();
    hsel = 1'b0; htrans = HTRANS_IDLE;
    tick();
    chk("err2_ign_resp", 32'(resp), 32'd1);
    hsel = 1'b1; haddr = 32'h40; htrans = HTRANS_NONSEQ;
    tick();
    chk("err2_ign_hready", 32'(rdy), 32'd1);
    chk("err2_ign_hresp", 32'(resp), 32'd0);
    hsel = 1'b0; htrans = HTRANS_IDLE;
    tick();
    m_open[1] = 1'b0;

    // Zero-wait write followed immediately by a read of the same word.
    sel = 1'b0;
    hsel = 1'b1; haddr = 32'h8; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hburst = BURST_SINGLE; hsize = HSIZE_WORD;
    tick();
    chk("fwd_wr_hready", 32'(rdy), 32'd1);
    hwdata = 32'h11; hwrite = 1'b0;
    tick();
    chk("fwd_rd_hready", 32'(rdy), 32'd1);
    chk("fwd_rd_hresp", 32'(resp), 32'd0);
    chk("fwd_rd_hrdata", rd, 32'h11);
    hsel = 1'b0; htrans = HTRANS_IDLE;
    tick();
    mdl_mem[0][2] = 32'h11; mdl_rd[0] = 32'h11; m_open[0] = 1'b0;
    xfer(32'h8, 1'b0, 32'h0, BURST_SINGLE, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, "fwd_reread");

    for (int it = 0; it < 80; it++) begin
      sel  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 4);
      wr   = 1'($urandom_range(0, 1));
      d    = $urandom;
      a    = 32'($urandom_range(0, 63) * 4);
      case (kind)
        0: xfer(a, 1'b0, d, BURST_SINGLE, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, "rnd_rd");
        1: xfer(a, 1'b1, d, BURST_SINGLE, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, "rnd_wr");
        2: begin
          sub = $urandom_range(0, 4);
          bu = BURST_SINGLE; sz = HSIZE_WORD; tr = HTRANS_NONSEQ;
          case (sub)
            0: a = a + 32'($urandom_range(1, 3));
            1: a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255) * 4);
            2: bu = ($urandom_range(0, 1) == 0) ? BURST_INCR : 4'($urandom_range(3, 15));
            3: sz = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(3, 7));
            default: tr = HTRANS_SEQ;
          endcase
          xfer(a, wr, d, bu, tr, sz, 1'b0, "rnd_err");
        end
        default: begin
          for (int b = 0; b < 4; b++) begin
            corrupt = (b > 0) && ($urandom_range(0, 7) == 0);
            if (b > 0) a = wrap_next(sel);
            if (corrupt) a = a ^ 32'h4;
            wr = 1'($urandom_range(0, 1));
            xfer(a, wr, $urandom, BURST_WRAP4, (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
                 HSIZE_WORD, (b < 3) && !corrupt, "rnd_wrap");
            if (corrupt) break;
          end
        end
      endcase
    end

    // Reset while a write sits in its wait state: the write must be dropped.
    sel = 1'b1;
    xfer(32'h80, 1'b1, 32'h1234_5678, BURST_SINGLE, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, "rst_pre");
    xfer(32'h80, 1'b0, 32'h0, BURST_SINGLE, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, "rst_pre_rd");
    hsel = 1'b1; haddr = 32'h80; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hburst = BURST_SINGLE; hsize = HSIZE_WORD;
    tick();
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hCAFE_F00D;
    chk("rst_wait_hready", 32'(rdy), 32'd0);
    rstn = 1'b0;
    tick();
    chk("rst_mid_hready", 32'(rdy), 32'd1);
    chk("rst_mid_hresp", 32'(resp), 32'd0);
    chk("rst_mid_hrdata", rd, 32'd0);
    chk("rst_mid_hrdata0", bus0.hrdata, 32'd0);
    rstn = 1'b1;
    for (int s = 0; s < 2; s++) begin
      mdl_rd[s] = '0; m_open[s] = 1'b0;
    end
    tick();
    xfer(32'h80, 1'b0, 32'h0, BURST_SINGLE, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, "rst_post_rd");
    chk("rst_post_value", mdl_rd[1], 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
